// File: rtl/loader_pkg.sv
// Shared definitions for the memory loader: FSM state encoding, command
// opcodes, target selectors and a byte-select helper.
// Optional feature macro: LOADER_CHECKSUM_EN (adds the CSUM state).
package loader_pkg;

    localparam int unsigned RD_LAT_DEF = 1;
    localparam int unsigned LEN_W_DEF  = 16;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_HDR        = 3'd1,
        ST_WR_COLLECT = 3'd2,
        ST_WR_ISSUE   = 3'd3,
        ST_RD_ISSUE   = 3'd4,
        ST_RD_WAIT    = 3'd5,
        ST_RD_SEND    = 3'd6
`ifdef LOADER_CHECKSUM_EN
        ,
        ST_CSUM       = 3'd7
`endif
    } state_t;

    // Command byte bits [7:6].
    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_READ  = 2'b01,
        OP_RUN   = 2'b10,
        OP_HALT  = 2'b11
    } op_t;

    // Command byte bit [0].
    localparam logic TGT_IMEM = 1'b0;
    localparam logic TGT_DMEM = 1'b1;

    // Pick byte 'idx' (0 = LSB) out of a 32-bit word.
    function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/loader_word_packer.sv
// Assembles four inbound bytes into a little-endian 32-bit word.
// word_o is the word as it will be once the current byte is taken, so the
// caller can register it on the same edge that accepts the final byte.
module loader_word_packer (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        clr_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        last_o
);

    logic [1:0]  idx_q;
    logic [23:0] bytes_q;

    // Shift each accepted byte in from the top; the first byte ends up in [7:0].
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            idx_q   <= 2'd0;
            bytes_q <= 24'h0;
        end else if (clr_i) begin
            idx_q   <= 2'd0;
            bytes_q <= 24'h0;
        end else if (byte_valid_i) begin
            idx_q   <= idx_q + 2'd1;
            bytes_q <= {byte_i, bytes_q[23:8]};
        end
    end

    assign last_o = byte_valid_i && (idx_q == 2'd3);
    assign word_o = {byte_i, bytes_q};

endmodule

// File: rtl/mem_loader.sv
// Host-side loader: decodes a byte-stream command protocol and drives the
// CPU's external imem (*_ext) and dmem (*_ext_2) ports, and owns cpu_enable.
// Optional feature macro: LOADER_CHECKSUM_EN (XOR checksum byte after WRITE).
//
// Handshakes: a byte moves on s_* (or m_*) in a cycle where valid and ready
// are both high at the rising edge; a source holds valid and data stable until
// that happens, and ready never depends combinationally on valid.
module mem_loader
    import loader_pkg::*;
#(
    parameter int unsigned RD_LAT = RD_LAT_DEF,
    parameter int unsigned LEN_W  = LEN_W_DEF
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [7:0]  s_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [7:0]  m_data,
    output logic [31:0] addr_ext,
    output logic        wen_ext,
    output logic        ren_ext,
    output logic [31:0] wdata_ext,
    input  logic [31:0] rdata_ext,
    output logic [31:0] addr_ext_2,
    output logic        wen_ext_2,
    output logic        ren_ext_2,
    output logic [31:0] wdata_ext_2,
    input  logic [31:0] rdata_ext_2,
    output logic        cpu_enable,
    output logic        busy,
    output state_t      dbg_state
);

    state_t            state_q;
    op_t               op_q;
    logic              tgt_q;
    logic [1:0]        hdr_idx_q;
    logic [15:0]       addr_q;
    logic [LEN_W-1:0]  cnt_q;
    logic [3:0]        wait_q;
    logic [31:0]       rdata_q;
    logic [1:0]        send_idx_q;
    logic              s_ready_q;
    logic              m_valid_q;
    logic [7:0]        m_data_q;
    logic              wen_q;
    logic              wen2_q;
    logic              ren_q;
    logic              ren2_q;
    logic [31:0]       wdata_q;
    logic              cpu_en_q;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        csum_q;
`endif

    logic              s_fire_d;
    logic              m_fire_d;
    logic              last_word_d;
    logic [31:0]       rdata_d;
    logic [31:0]       pk_word_d;
    logic              pk_last_d;
    logic              pk_clr_d;
    logic              pk_valid_d;

    assign s_fire_d    = s_valid && s_ready_q;
    assign m_fire_d    = m_valid_q && m_ready;
    assign last_word_d = (cnt_q == LEN_W'(1));
    assign rdata_d     = (tgt_q == TGT_DMEM) ? rdata_ext_2 : rdata_ext;
    assign pk_clr_d    = s_fire_d && (state_q == ST_IDLE);
    assign pk_valid_d  = s_fire_d && (state_q == ST_WR_COLLECT);

    loader_word_packer u_packer (
        .clk          (clk),
        .arst_n       (arst_n),
        .clr_i        (pk_clr_d),
        .byte_valid_i (pk_valid_d),
        .byte_i       (s_data),
        .word_o       (pk_word_d),
        .last_o       (pk_last_d)
    );

    // Command FSM; every output is a flop loaded with its value for the next state.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_WRITE;
            tgt_q      <= TGT_IMEM;
            hdr_idx_q  <= 2'd0;
            addr_q     <= 16'h0;
            cnt_q      <= '0;
            wait_q     <= 4'd0;
            rdata_q    <= 32'h0;
            send_idx_q <= 2'd0;
            s_ready_q  <= 1'b0;
            m_valid_q  <= 1'b0;
            m_data_q   <= 8'h0;
            wen_q      <= 1'b0;
            wen2_q     <= 1'b0;
            ren_q      <= 1'b0;
            ren2_q     <= 1'b0;
            wdata_q    <= 32'h0;
            cpu_en_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= 8'h0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    s_ready_q <= 1'b1;
                    if (s_fire_d) begin
                        op_q  <= op_t'(s_data[7:6]);
                        tgt_q <= s_data[0];
                        case (op_t'(s_data[7:6]))
                            OP_RUN:  cpu_en_q <= 1'b1;
                            OP_HALT: cpu_en_q <= 1'b0;
                            default: begin
                                // CPU must be stopped before the loader touches its memories.
                                cpu_en_q  <= 1'b0;
                                hdr_idx_q <= 2'd0;
                                state_q   <= ST_HDR;
                            end
                        endcase
                    end
                end
                ST_HDR: begin
                    if (s_fire_d) begin
                        hdr_idx_q <= hdr_idx_q + 2'd1;
                        case (hdr_idx_q)
                            2'd0: addr_q <= {addr_q[15:8], s_data[7:2], 2'b00};
                            2'd1: addr_q <= {s_data, addr_q[7:0]};
                            2'd2: cnt_q  <= LEN_W'(s_data);
                            default: begin
                                cnt_q <= LEN_W'({s_data, cnt_q[7:0]});
`ifdef LOADER_CHECKSUM_EN
                                csum_q <= 8'h0;
`endif
                                if ({s_data, cnt_q[7:0]} == 16'h0) begin
                                    state_q <= ST_IDLE;
                                end else if (op_q == OP_WRITE) begin
                                    state_q <= ST_WR_COLLECT;
                                end else begin
                                    state_q   <= ST_RD_ISSUE;
                                    s_ready_q <= 1'b0;
                                    ren_q     <= (tgt_q == TGT_IMEM);
                                    ren2_q    <= (tgt_q == TGT_DMEM);
                                end
                            end
                        endcase
                    end
                end
                ST_WR_COLLECT: begin
                    if (s_fire_d) begin
`ifdef LOADER_CHECKSUM_EN
                        csum_q <= csum_q ^ s_data;
`endif
                        if (pk_last_d) begin
                            state_q   <= ST_WR_ISSUE;
                            s_ready_q <= 1'b0;
                            wdata_q   <= pk_word_d;
                            wen_q     <= (tgt_q == TGT_IMEM);
                            wen2_q    <= (tgt_q == TGT_DMEM);
                        end
                    end
                end
                ST_WR_ISSUE: begin
                    wen_q  <= 1'b0;
                    wen2_q <= 1'b0;
                    addr_q <= addr_q + 16'd4;
                    cnt_q  <= cnt_q - LEN_W'(1);
                    if (last_word_d) begin
`ifdef LOADER_CHECKSUM_EN
                        state_q   <= ST_CSUM;
                        m_valid_q <= 1'b1;
                        m_data_q  <= csum_q;
`else
                        state_q   <= ST_IDLE;
                        s_ready_q <= 1'b1;
`endif
                    end else begin
                        state_q   <= ST_WR_COLLECT;
                        s_ready_q <= 1'b1;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                ST_CSUM: begin
                    if (m_fire_d) begin
                        m_valid_q <= 1'b0;
                        state_q   <= ST_IDLE;
                        s_ready_q <= 1'b1;
                    end
                end
`endif
                ST_RD_ISSUE: begin
                    ren_q   <= 1'b0;
                    ren2_q  <= 1'b0;
                    wait_q  <= 4'(RD_LAT - 1);
                    state_q <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    if (wait_q == 4'd0) begin
                        rdata_q    <= rdata_d;
                        m_data_q   <= rdata_d[7:0];
                        m_valid_q  <= 1'b1;
                        send_idx_q <= 2'd0;
                        state_q    <= ST_RD_SEND;
                    end else begin
                        wait_q <= wait_q - 4'd1;
                    end
                end
                ST_RD_SEND: begin
                    if (m_fire_d) begin
                        if (send_idx_q == 2'd3) begin
                            m_valid_q <= 1'b0;
                            addr_q    <= addr_q + 16'd4;
                            cnt_q     <= cnt_q - LEN_W'(1);
                            if (last_word_d) begin
                                state_q   <= ST_IDLE;
                                s_ready_q <= 1'b1;
                            end else begin
                                state_q <= ST_RD_ISSUE;
                                ren_q   <= (tgt_q == TGT_IMEM);
                                ren2_q  <= (tgt_q == TGT_DMEM);
                            end
                        end else begin
                            send_idx_q <= send_idx_q + 2'd1;
                            m_data_q   <= byte_sel(rdata_q, send_idx_q + 2'd1);
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Both ports share the address and write-data registers; only the strobes are per port.
    assign s_ready     = s_ready_q;
    assign m_valid     = m_valid_q;
    assign m_data      = m_data_q;
    assign addr_ext    = {16'h0, addr_q};
    assign addr_ext_2  = {16'h0, addr_q};
    assign wdata_ext   = wdata_q;
    assign wdata_ext_2 = wdata_q;
    assign wen_ext     = wen_q;
    assign wen_ext_2   = wen2_q;
    assign ren_ext     = ren_q;
    assign ren_ext_2   = ren2_q;
    assign cpu_enable  = cpu_en_q;
    assign busy        = (state_q != ST_IDLE);
    assign dbg_state   = state_q;

endmodule
